// File: rtl/mult_seq_nxn.sv
// rtl/mult_seq_nxn.sv - sequential shift-add WIDTHxWIDTH multiplier with start/busy/Finish handshake
module mult_seq_nxn #(
    parameter int WIDTH     = 4,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 mode_signed,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   O,
    output logic                 Finish,
    output logic                 busy
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [PW-1:0]    mcand;
    logic [PW-1:0]    acc;
    logic [WIDTH-1:0] mplier;
    logic             neg;
    logic [CW-1:0]    cnt;

    logic             use_signed;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic             neg_in;

    // Magnitudes are WIDTH-bit unsigned, so the most negative operand still fits.
    always_comb begin
        use_signed = SIGNED_EN && mode_signed;
        abs_a      = (use_signed && A[WIDTH-1]) ? (~A + 1'b1) : A;
        abs_b      = (use_signed && B[WIDTH-1]) ? (~B + 1'b1) : B;
        neg_in     = use_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = CALC;
            CALC: if (cnt == LAST) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Multiplicand is pre-widened and shifted left each step instead of a barrel shift by cnt.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            neg    <= 1'b0;
            cnt    <= '0;
            O      <= '0;
            Finish <= 1'b0;
        end else begin
            Finish <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= {{WIDTH{1'b0}}, abs_a};
                        mplier <= abs_b;
                        neg    <= neg_in;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                CALC: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                end
                DONE: begin
                    O      <= neg ? (~acc + 1'b1) : acc;
                    Finish <= 1'b1;
                end
                default: begin
                    Finish <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_nxn.sv
// tb/tb_mult_seq_nxn.sv - directed self-checking bench for mult_seq_nxn
module tb_mult_seq_nxn;

    logic clk = 1'b0;
    logic reset;

    logic       start4, ms4;
    logic [3:0] a4, b4;
    logic [7:0] o4;
    logic       fin4, busy4;

    logic       start8s, ms8s;
    logic [7:0] a8s, b8s;
    logic [15:0] o8s;
    logic       fin8s, busy8s;

    logic       start8u, ms8u;
    logic [7:0] a8u, b8u;
    logic [15:0] o8u;
    logic       fin8u, busy8u;

    int         checks = 0;
    int         failures = 0;

    int          sel;
    logic [63:0] o_sel;
    logic        fin_sel;
    logic        busy_sel;

    always #5 clk = ~clk;

    mult_seq_nxn #(.WIDTH(4), .SIGNED_EN(1'b1)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .mode_signed(ms4),
        .A(a4), .B(b4), .O(o4), .Finish(fin4), .busy(busy4)
    );

    mult_seq_nxn #(.WIDTH(8), .SIGNED_EN(1'b1)) dut8s (
        .clk(clk), .reset(reset), .start(start8s), .mode_signed(ms8s),
        .A(a8s), .B(b8s), .O(o8s), .Finish(fin8s), .busy(busy8s)
    );

    mult_seq_nxn #(.WIDTH(8), .SIGNED_EN(1'b0)) dut8u (
        .clk(clk), .reset(reset), .start(start8u), .mode_signed(ms8u),
        .A(a8u), .B(b8u), .O(o8u), .Finish(fin8u), .busy(busy8u)
    );

    always_comb begin
        o_sel    = '0;
        fin_sel  = 1'b0;
        busy_sel = 1'b0;
        case (sel)
            0: begin o_sel = {56'b0, o4};  fin_sel = fin4;  busy_sel = busy4;  end
            1: begin o_sel = {48'b0, o8s}; fin_sel = fin8s; busy_sel = busy8s; end
            default: begin o_sel = {48'b0, o8u}; fin_sel = fin8u; busy_sel = busy8u; end
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int which, input logic st, input logic ms,
                         input logic [7:0] a, input logic [7:0] b);
        case (which)
            0: begin start4 = st;  ms4 = ms;  a4 = a[3:0]; b4 = b[3:0]; end
            1: begin start8s = st; ms8s = ms; a8s = a;     b8s = b;     end
            default: begin start8u = st; ms8u = ms; a8u = a; b8u = b; end
        endcase
    endtask

    task automatic run_op(input string tag, input int which, input logic ms,
                          input logic [7:0] a, input logic [7:0] b,
                          input logic [63:0] exp_o, input int exp_lat);
        int lat;
        sel = which;
        drive(which, 1'b1, ms, a, b);
        tick();
        drive(which, 1'b0, ms, a, b);
        check({tag, "_busy"}, {63'b0, busy_sel}, 64'd1);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            lat++;
            if (fin_sel) break;
        end
        check({tag, "_finish"}, {63'b0, fin_sel}, 64'd1);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_o"}, o_sel, exp_o);
        check({tag, "_busy_done"}, {63'b0, busy_sel}, 64'd0);
        tick();
        check({tag, "_finish_low"}, {63'b0, fin_sel}, 64'd0);
    endtask

    initial begin
        int fcount;
        int first_t;
        int last_t;
        int gap_bad;

        sel = 0;
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(2, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        tick();
        check("rst_o4", {56'b0, o4}, 64'h0);
        check("rst_fin4", {63'b0, fin4}, 64'd0);
        check("rst_busy4", {63'b0, busy4}, 64'd0);
        check("rst_o8s", {48'b0, o8s}, 64'h0);
        reset = 1'b0;
        tick();

        // Test 1: unsigned 14*11, then O must hold.
        run_op("u14x11", 0, 1'b0, 8'd14, 8'd11, 64'h9A, 5);
        for (int i = 0; i < 20; i++) tick();
        check("u14x11_hold", {56'b0, o4}, 64'h9A);

        // Test 2: signed cases.
        run_op("s_m2xm5", 0, 1'b1, 8'h0E, 8'h0B, 64'h0A, 5);
        run_op("s_m8xm8", 0, 1'b1, 8'h08, 8'h08, 64'h40, 5);
        run_op("s_m8x7", 0, 1'b1, 8'h08, 8'h07, 64'hC8, 5);
        run_op("s_0xm7", 0, 1'b1, 8'h00, 8'h09, 64'h00, 5);

        // Test 3: 15*15, then start held high for back-to-back results.
        run_op("u15x15", 0, 1'b0, 8'h0F, 8'h0F, 64'hE1, 5);
        drive(0, 1'b1, 1'b0, 8'h0F, 8'h0F);
        fcount = 0; first_t = 0; last_t = 0; gap_bad = 0;
        for (int t = 1; t <= 30; t++) begin
            tick();
            if (fin4) begin
                if (fcount > 0 && (t - last_t) != 6) gap_bad++;
                if (fcount == 0) first_t = t;
                if (o4 !== 8'hE1) gap_bad++;
                last_t = t;
                fcount++;
            end
        end
        drive(0, 1'b0, 1'b0, 8'h0F, 8'h0F);
        check("b2b_count", 64'(fcount), 64'd5);
        check("b2b_first", 64'(first_t), 64'd6);
        check("b2b_gap_and_value", 64'(gap_bad), 64'd0);
        for (int i = 0; i < 8; i++) tick();

        // Start pulses while busy must be ignored.
        drive(0, 1'b1, 1'b0, 8'd3, 8'd3);
        tick();
        drive(0, 1'b0, 1'b0, 8'd3, 8'd3);
        tick();
        drive(0, 1'b1, 1'b0, 8'd7, 8'd7);
        tick();
        drive(0, 1'b0, 1'b0, 8'd7, 8'd7);
        fcount = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (fin4) fcount++;
        end
        check("busy_ign_count", 64'(fcount), 64'd1);
        check("busy_ign_o", {56'b0, o4}, 64'h09);

        // Test 4: reset two cycles into an operation.
        drive(0, 1'b1, 1'b0, 8'd15, 8'd15);
        tick();
        drive(0, 1'b0, 1'b0, 8'd15, 8'd15);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_o", {56'b0, o4}, 64'h0);
        check("abort_busy", {63'b0, busy4}, 64'd0);
        check("abort_fin", {63'b0, fin4}, 64'd0);
        fcount = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (fin4) fcount++;
        end
        check("abort_no_finish", 64'(fcount), 64'd0);
        run_op("u3x5", 0, 1'b0, 8'd3, 8'd5, 64'h0F, 5);

        // Test 5: WIDTH=8 signed-capable.
        run_op("w8_u255", 1, 1'b0, 8'hFF, 8'hFF, 64'hFE01, 9);
        run_op("w8_s80x80", 1, 1'b1, 8'h80, 8'h80, 64'h4000, 9);
        run_op("w8_s80x01", 1, 1'b1, 8'h80, 8'h01, 64'hFF80, 9);

        // Test 6: WIDTH=8 with signed mode disabled.
        run_op("w8u_ffx02", 2, 1'b1, 8'hFF, 8'h02, 64'h01FE, 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_seq_nxn.md
Name: mult_seq_nxn

Overview:
Parametrised sequential shift-add multiplier; the successor to the fixed 4x4 sequential multiplier. Supports WIDTH-bit operands, selectable signed/unsigned mode per operation, and a start/busy/Finish handshake with a registered, held result. Used wherever the datapath needs area-cheap multiplication and can accept WIDTH+1 cycles of latency.

Parameters:
WIDTH, 4, operand width in bits (legal 2..32); the product is 2*WIDTH bits.
SIGNED_EN, 1, 1 = mode_signed input honoured; 0 = mode_signed ignored, always unsigned.

Ports:
clk  input  1  clock; all state changes on the rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request a multiply; sampled only while idle
mode_signed  input  1  1 = A and B are two's complement, O is signed; sampled with start
A  input  WIDTH  multiplicand, sampled on the accepting edge
B  input  WIDTH  multiplier, sampled on the accepting edge
O  output  2*WIDTH  product; registered, held until the next Finish
Finish  output  1  one-cycle pulse: O is valid and newly updated
busy  output  1  high while an operation is in flight

Behaviour:
- Clock is clk. Reset is synchronous and active-high on reset: at any rising edge with reset=1, state=IDLE, O=0, Finish=0, busy=0, counter=0, and internal accumulators are cleared. Reset overrides start.
- FSM states:
  - IDLE: busy=0. start=1 at an edge -> capture operands, counter=0, go to CALC, busy=1.
  - CALC: one shift-add iteration per edge. After WIDTH iterations -> go to DONE.
  - DONE: for one edge, apply sign correction, write O, pulse Finish=1, clear busy, go to IDLE.
- Operand capture:
  - Unsigned mode: magA=A, magB=B, neg=0.
  - Signed mode: magA=|A|, magB=|B| (WIDTH-bit unsigned, so |-2^(WIDTH-1)| = 2^(WIDTH-1) fits), neg=A[msb]^B[msb].
- Iteration: if multiplier LSB=1, add magA<<count into the 2*WIDTH-bit accumulator; shift the multiplier right by 1; counter+1. The accumulator never overflows 2*WIDTH bits.
- Final result: O = neg ? -acc : acc (two's complement, 2*WIDTH bits). A zero product with neg=1 yields 0.
- Latency and timing, with start accepted at edge k:
  - busy=1 after edge k.
  - Finish=1 and O updated after edge k+WIDTH+1; Finish returns to 0 after edge k+WIDTH+2.
  - busy=0 from edge k+WIDTH+1 onward.
- Back-to-back: start=1 during the Finish cycle is accepted, because the FSM is already in IDLE.
- start while busy=1 is ignored; no queuing. A and B changing mid-operation have no effect.
- O holds its last value between operations. It changes only on a Finish edge or on reset.
- Reset mid-operation aborts: no Finish pulse, O=0, and the block is ready for start on the next edge.
- SIGNED_EN=0 removes the abs/negate logic; mode_signed is a don't-care.

Test Plan:
1. WIDTH=4, unsigned: after reset, A=14, B=11, start pulse -> Finish pulses exactly 5 cycles after the accepting edge, O=8'h9A (154); O still 8'h9A 20 cycles later.
2. WIDTH=4, signed: A=4'hE (-2), B=4'hB (-5) -> O=8'h0A. Then A=4'h8, B=4'h8 -> O=8'h40. Then A=4'h8, B=4'h7 -> O=8'hC8 (-56). Then A=0, B=4'h9 -> O=0.
3. WIDTH=4, unsigned: A=15, B=15 -> O=8'hE1. Hold start high continuously -> results arrive every 6 cycles; start pulses asserted while busy=1 are ignored (Finish count matches accepted starts only).
4. Reset mid-operation: assert reset 2 cycles after start -> next edge O=0, busy=0, Finish=0, and no Finish pulse follows; a new start (A=3, B=5) then gives O=8'h0F.
5. WIDTH=8, SIGNED_EN=1: unsigned 255*255 -> O=16'hFE01 after 9 cycles; signed 8'h80*8'h80 -> O=16'h4000; signed 8'h80*8'h01 -> O=16'hFF80.
6. WIDTH=8, SIGNED_EN=0: mode_signed=1, A=8'hFF, B=8'h02 -> O=16'h01FE (unsigned result).
